// File: rtl/viterbi_frame_encoder_pkg.sv
// Shared definitions for the transmit-side convolutional frame encoder:
// code width, default constraint length and generator polynomials,
// FSM state encoding and the parity helper used by the shift core.
package viterbi_frame_encoder_pkg;

  localparam int WD_CODE = 2;                 // rate-1/2: two code bits per input bit
  localparam int VD_K    = 9;                 // constraint length
  localparam int VD_TAIL = VD_K - 1;          // zero bits flushed after each frame

  // Bit K-1 of each polynomial taps the bit being consumed this tick.
  localparam logic [VD_K-1:0] VD_G0 = 9'o561; // drives Code[1]
  localparam logic [VD_K-1:0] VD_G1 = 9'o753; // drives Code[0]

  typedef logic [WD_CODE-1:0] code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } enc_state_e;

endpackage

// File: rtl/viterbi_frame_encoder_if.sv
// Source-side handshake plus code/status outputs of the frame encoder.
// master = data source / decoder side, slave = the encoder itself.
interface viterbi_frame_encoder_if;
  import viterbi_frame_encoder_pkg::*;

  logic  InValid;
  logic  InBit;
  logic  InLast;
  logic  InReady;
  code_t ErrInject;
  code_t Code;
  logic  CodeValid;
  logic  Active;
  logic  FrameDone;
  logic  Underrun;

  modport master (
    output InValid, InBit, InLast, ErrInject,
    input  InReady, Code, CodeValid, Active, FrameDone, Underrun
  );

  modport slave (
    input  InValid, InBit, InLast, ErrInject,
    output InReady, Code, CodeValid, Active, FrameDone, Underrun
  );
endinterface

// File: rtl/viterbi_frame_encoder_conv_shift_core.sv
// Convolutional encoder core: K-1 bit history register plus the two
// generator parity trees. Shifts one bit per Shift pulse and registers the
// resulting (optionally error-masked) code symbol. Kept free of framing
// logic so the decoder's traceback self-check can reuse it.
module viterbi_frame_encoder_conv_shift_core
  import viterbi_frame_encoder_pkg::*;
#(
  parameter int           K  = VD_K,
  parameter logic [K-1:0] G0 = VD_G0,
  parameter logic [K-1:0] G1 = VD_G1
) (
  input  logic         CLOCK,
  input  logic         Reset,
  input  logic         Shift,
  input  logic         Bit,
  input  code_t        Mask,
  output code_t        Code,
  output logic [K-2:0] State
);

  // Encoding window: newest bit on top, older history below it.
  logic [K-1:0] window;
  assign window = {Bit, State};

  // Advance the history and register the masked symbol on each shift.
  // NOTE: registers are assigned with <= so every flop samples pre-edge
  // values; State on the right-hand side is the old history, as the code
  // symbol equation requires.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      State <= '0;
      Code  <= '0;
    end else if (Shift) begin
      Code  <= {^(window & G0), ^(window & G1)} ^ Mask;
      State <= {Bit, State[K-2:1]};
    end
  end

endmodule

// File: rtl/viterbi_frame_encoder.sv
// Frame encoder top: paces one code symbol every SYM_DIV clocks, accepts a
// serial bit stream with a ready/valid handshake, stuffs zeros on source
// underrun, appends K-1 zero tail bits per frame and raises Active/FrameDone
// for the downstream Viterbi decoder.
module viterbi_frame_encoder
  import viterbi_frame_encoder_pkg::*;
#(
  parameter int           SYM_DIV = 4,
  parameter int           K       = VD_K,
  parameter logic [K-1:0] G0      = VD_G0,
  parameter logic [K-1:0] G1      = VD_G1
) (
  input logic                   CLOCK,
  input logic                   Reset,
  viterbi_frame_encoder_if.slave bus
);

  localparam int CNT_W    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam int TAIL_LEN = K - 1;
  localparam int TAIL_W   = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  enc_state_e        state, state_nxt;
  logic [TAIL_W-1:0] tail_cnt, tail_cnt_nxt;

  logic              shift;
  logic              shift_bit;
  code_t             shift_mask;
  logic              emit;
  logic              set_active;
  logic              set_underrun;
  logic              last_tail;
  logic              last_tail_q;
  logic [K-2:0]      sr;

  // Free-running symbol pacing counter; tick marks the last clock of a symbol.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick        = (tick_cnt == CNT_W'(SYM_DIV - 1));
  assign bus.InReady = tick && ((state == ST_IDLE) || (state == ST_DATA));

  // State and tail counter registers.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      tail_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tail_cnt <= tail_cnt_nxt;
    end
  end

  // Next-state and per-tick shift control; everything idles between ticks.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    tail_cnt_nxt = tail_cnt;
    shift        = 1'b0;
    shift_bit    = 1'b0;
    shift_mask   = '0;
    emit         = 1'b0;
    set_active   = 1'b0;
    set_underrun = 1'b0;
    last_tail    = 1'b0;
    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          // An idle tick shifts a zero into the (already zero) history,
          // which forces Code back to 00 without emitting a symbol.
          shift = 1'b1;
          if (bus.InValid) begin
            shift_bit  = bus.InBit;
            shift_mask = bus.ErrInject;
            emit       = 1'b1;
            set_active = 1'b1;
            if (bus.InLast) begin
              state_nxt    = ST_TAIL;
              tail_cnt_nxt = '0;
            end else begin
              state_nxt = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          shift      = 1'b1;
          emit       = 1'b1;
          shift_mask = bus.ErrInject;
          if (bus.InValid) begin
            shift_bit = bus.InBit;
            if (bus.InLast) begin
              state_nxt    = ST_TAIL;
              tail_cnt_nxt = '0;
            end
          end else begin
            // Source starved: keep the symbol rate by stuffing a zero bit.
            set_underrun = 1'b1;
          end
        end
        ST_TAIL: begin
          shift        = 1'b1;
          emit         = 1'b1;
          shift_mask   = bus.ErrInject;
          tail_cnt_nxt = tail_cnt + 1'b1;
          if (tail_cnt == TAIL_W'(TAIL_LEN - 1)) begin
            state_nxt    = ST_IDLE;
            tail_cnt_nxt = '0;
            last_tail    = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status flags: CodeValid tracks the Code register, Active/Underrun are
  // sticky, FrameDone follows one cycle after the final tail symbol.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      bus.CodeValid <= 1'b0;
      bus.Active    <= 1'b0;
      bus.Underrun  <= 1'b0;
      bus.FrameDone <= 1'b0;
      last_tail_q   <= 1'b0;
    end else begin
      bus.CodeValid <= emit;
      bus.Active    <= bus.Active | set_active;
      bus.Underrun  <= bus.Underrun | set_underrun;
      last_tail_q   <= last_tail;
      bus.FrameDone <= last_tail_q;
    end
  end

  viterbi_frame_encoder_conv_shift_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .CLOCK (CLOCK),
    .Reset (Reset),
    .Shift (shift),
    .Bit   (shift_bit),
    .Mask  (shift_mask),
    .Code  (bus.Code),
    .State (sr)
  );

  // Every frame ends with K-1 zero bits, so the history is clear whenever idle.
  a_idle_history_clear : assert property (
    @(posedge CLOCK) disable iff (!Reset) (state == ST_IDLE) |-> (sr == '0)
  );

endmodule

// File: tb/tb_viterbi_frame_encoder.sv
// Self-checking bench for viterbi_frame_encoder. Two instances: SYM_DIV=1
// for framing/tail/error/underrun/reset scenarios, SYM_DIV=4 for pacing.
// Expected symbols come from an independent bit-serial encoder model and
// are queued when a bit is driven, then popped when CodeValid is seen.
module tb_viterbi_frame_encoder;
  import viterbi_frame_encoder_pkg::*;

  logic CLOCK  = 1'b0;
  logic Reset1 = 1'b0;
  logic Reset4 = 1'b0;

  always #5 CLOCK = ~CLOCK;

  viterbi_frame_encoder_if if1();
  viterbi_frame_encoder_if if4();

  viterbi_frame_encoder #(.SYM_DIV(1)) dut1 (.CLOCK(CLOCK), .Reset(Reset1), .bus(if1));
  viterbi_frame_encoder #(.SYM_DIV(4)) dut4 (.CLOCK(CLOCK), .Reset(Reset4), .bus(if4));

  // Polynomials written out in binary: 561 and 753 octal.
  localparam logic [8:0] TB_G0 = 9'b101_110_001;
  localparam logic [8:0] TB_G1 = 9'b111_101_011;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];
  logic [7:0] sr_m = '0;
  logic [1:0] exp4_q[$];
  logic [7:0] sr4_m = '0;

  typedef struct {
    logic       b;
    logic       last;
    logic [1:0] err;
    logic [1:0] code;
    bit         use_code;
  } vec_t;

  vec_t tab[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [7:0] sr, input logic b, input logic [1:0] m);
    logic [8:0] w;
    logic p1, p0;
    w  = {b, sr};
    p1 = m[1];
    p0 = m[0];
    for (int k = 0; k < 9; k++) begin
      if (TB_G0[k]) p1 ^= w[k];
      if (TB_G1[k]) p0 ^= w[k];
    end
    return {p1, p0};
  endfunction

  // Scoreboard for the SYM_DIV=1 instance.
  always @(negedge CLOCK) begin
    if (if1.CodeValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected CodeValid: got Code=%b, required no symbol", if1.Code);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("dut1 code", int'(if1.Code), int'(e));
        check("dut1 active with symbol", int'(if1.Active), 1);
      end
    end
  end

  // Offer one bit to dut1; queue its expected symbol (and tail if last).
  task automatic send_bit(input logic b, input logic last, input logic [1:0] err,
                          input logic [1:0] code, input bit use_code);
    int n;
    logic [1:0] c;
    @(negedge CLOCK);
    if1.InValid   = 1'b1;
    if1.InBit     = b;
    if1.InLast    = last;
    if1.ErrInject = err;
    n = 0;
    while (!if1.InReady && n < 64) begin
      @(negedge CLOCK);
      n++;
    end
    if (!if1.InReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_bit timeout: InReady=0, required 1");
    end
    c    = enc(sr_m, b, err);
    sr_m = {b, sr_m[7:1]};
    exp_q.push_back(use_code ? code : c);
    if (last) begin
      for (int t = 0; t < 8; t++) begin
        exp_q.push_back(enc(sr_m, 1'b0, 2'b00));
        sr_m = {1'b0, sr_m[7:1]};
      end
    end
  endtask

  // Observe the tail after the last accept (SYM_DIV=1 timing is exact).
  task automatic wait_frame_end(input string tag);
    int tails, fd, fd_i, cv_i, ir_bad;
    tails = 0; fd = 0; fd_i = -1; cv_i = -1; ir_bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK);
      if (i == 0) begin
        if1.InValid   = 1'b0;
        if1.InLast    = 1'b0;
        if1.InBit     = 1'b0;
        if1.ErrInject = 2'b00;
      end
      if (if1.CodeValid && i > 0) begin
        tails++;
        cv_i = i;
      end
      if (if1.FrameDone) begin
        fd++;
        fd_i = i;
      end
      if (tails < 8 && if1.InReady) ir_bad = 1;
    end
    check({tag, " tail symbol count"}, tails, 8);
    check({tag, " last tail cycle"}, cv_i, 8);
    check({tag, " FrameDone pulses"}, fd, 1);
    check({tag, " FrameDone cycle"}, fd_i, 9);
    check({tag, " InReady during tail"}, ir_bad, 0);
    check({tag, " history cleared"}, int'(dut1.u_core.State), 0);
    check({tag, " idle Code"}, int'(if1.Code), 0);
    check({tag, " scoreboard drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] pat;
    logic [1:0]  prev_code;
    logic        prev_ir;
    int          ir_cnt, last_ir, gap_bad, tails;

    tab[0] = '{1'b1, 1'b0, 2'b00, 2'b11, 1'b1};
    tab[1] = '{1'b1, 1'b0, 2'b00, 2'b10, 1'b1};
    tab[2] = '{1'b0, 1'b1, 2'b00, 2'b10, 1'b1};
    tab[3] = '{1'b1, 1'b0, 2'b01, 2'b10, 1'b1};
    tab[4] = '{1'b1, 1'b0, 2'b00, 2'b10, 1'b1};
    tab[5] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    tab[6] = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b0};

    if1.InValid = 1'b0; if1.InBit = 1'b0; if1.InLast = 1'b0; if1.ErrInject = 2'b00;
    if4.InValid = 1'b0; if4.InBit = 1'b0; if4.InLast = 1'b0; if4.ErrInject = 2'b00;

    // Reset state.
    repeat (2) @(negedge CLOCK);
    check("reset Code", int'(if1.Code), 0);
    check("reset CodeValid", int'(if1.CodeValid), 0);
    check("reset Active", int'(if1.Active), 0);
    check("reset FrameDone", int'(if1.FrameDone), 0);
    check("reset Underrun", int'(if1.Underrun), 0);
    check("reset dut4 InReady", int'(if4.InReady), 0);

    // SYM_DIV=4 pacing with InValid held high.
    pat       = 24'b1011_0010_1110_0101_1100_1010;
    prev_ir   = 1'b0;
    ir_cnt    = 0;
    last_ir   = -1;
    gap_bad   = 0;
    Reset4    = 1'b1;
    if4.InValid = 1'b1;
    prev_code = if4.Code;
    for (int i = 0; i < 24; i++) begin
      @(negedge CLOCK);
      check("dut4 CodeValid follows InReady", int'(if4.CodeValid), int'(prev_ir));
      if (if4.CodeValid) begin
        if (exp4_q.size() > 0) begin
          logic [1:0] e;
          e = exp4_q.pop_front();
          check("dut4 code", int'(if4.Code), int'(e));
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL dut4 unexpected CodeValid: got Code=%b, required no symbol", if4.Code);
        end
      end else begin
        check("dut4 code stable", int'(if4.Code), int'(prev_code));
      end
      if4.InBit = pat[i];
      if (if4.InReady) begin
        if (last_ir >= 0 && i - last_ir != 4) gap_bad = 1;
        last_ir = i;
        ir_cnt++;
        exp4_q.push_back(enc(sr4_m, pat[i], 2'b00));
        sr4_m = {pat[i], sr4_m[7:1]};
      end
      prev_ir   = if4.InReady;
      prev_code = if4.Code;
    end
    check("dut4 InReady count in 24 clocks", ir_cnt, 6);
    check("dut4 InReady spacing", gap_bad, 0);
    check("dut4 Active", int'(if4.Active), 1);
    check("dut4 Underrun", int'(if4.Underrun), 0);
    Reset4 = 1'b0;

    // Table frames on dut1: 1,1,0(last) then error-injected frame.
    @(negedge CLOCK);
    Reset1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_bit(tab[i].b, tab[i].last, tab[i].err, tab[i].code, tab[i].use_code);
      if (tab[i].last) wait_frame_end($sformatf("frame%0d", i));
    end

    // Underrun: one DATA tick without InValid stuffs a zero.
    check("underrun before gap", int'(if1.Underrun), 0);
    send_bit(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    send_bit(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    @(negedge CLOCK);
    if1.InValid   = 1'b0;
    if1.ErrInject = 2'b00;
    check("underrun gap tick InReady", int'(if1.InReady), 1);
    exp_q.push_back(enc(sr_m, 1'b0, 2'b00));
    sr_m = {1'b0, sr_m[7:1]};
    send_bit(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    send_bit(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    wait_frame_end("underrun");
    check("underrun sticky", int'(if1.Underrun), 1);

    // Reset during tail symbol 4, then a fresh 1-bit frame.
    send_bit(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    send_bit(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    tails = 0;
    for (int i = 0; i < 20 && tails < 4; i++) begin
      @(negedge CLOCK);
      if (i == 0) begin
        if1.InValid = 1'b0;
        if1.InLast  = 1'b0;
      end
      if (if1.CodeValid && i > 0) tails++;
    end
    check("mid-tail reached symbol 4", tails, 4);
    #1 Reset1 = 1'b0;
    #1;
    check("abort Code", int'(if1.Code), 0);
    check("abort CodeValid", int'(if1.CodeValid), 0);
    check("abort Active", int'(if1.Active), 0);
    check("abort FrameDone", int'(if1.FrameDone), 0);
    check("abort Underrun", int'(if1.Underrun), 0);
    check("abort history", int'(dut1.u_core.State), 0);
    exp_q.delete();
    sr_m = '0;
    @(negedge CLOCK);
    Reset1 = 1'b1;
    check("restart Active before accept", int'(if1.Active), 0);
    send_bit(1'b1, 1'b1, 2'b00, 2'b11, 1'b1);
    wait_frame_end("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
